// File: rtl/rv32_pkg.sv
// Shared rv32 integer-pipeline types: default word/address widths,
// register address and data word typedefs, and the hardwired-zero register index.
// No logic; imported by the register file and its read ports.
package rv32_pkg;

  localparam int WORD_LENGTH = 32;
  localparam int ADDR_LENGTH = 5;

  typedef logic [ADDR_LENGTH-1:0] reg_addr_t;
  typedef logic [WORD_LENGTH-1:0] word_t;

  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: address decode, x0 check, optional same-cycle write bypass.
// Latency: zero cycles from ra / write inputs to rd / rd_busy.
// Backpressure: none; the port answers every cycle.
// Ports: reset forces outputs to 0; ra selects a word from the flattened storage image
// (mem) and busy vector; we/wa/wd/rsv_en/rsv_addr feed the bypass when REGFILE_BYPASS_EN
// is defined. Without that macro the read reflects stored state only.
module regfile_read_port
  import rv32_pkg::*;
#(
  parameter int WORD_LENGTH = rv32_pkg::WORD_LENGTH,
  parameter int ADDR_LENGTH = rv32_pkg::ADDR_LENGTH,
  parameter int NUM_WRITE   = 2
) (
  input  logic                                    reset,
  input  logic [ADDR_LENGTH-1:0]                  ra,
  input  logic [(2**ADDR_LENGTH)*WORD_LENGTH-1:0] mem,
  input  logic [(2**ADDR_LENGTH)-1:0]             busy,
  input  logic [NUM_WRITE-1:0]                    we,
  input  logic [NUM_WRITE*ADDR_LENGTH-1:0]        wa,
  input  logic [NUM_WRITE*WORD_LENGTH-1:0]        wd,
  input  logic                                    rsv_en,
  input  logic [ADDR_LENGTH-1:0]                  rsv_addr,
  output logic [WORD_LENGTH-1:0]                  rd,
  output logic                                    rd_busy
);

  localparam logic [ADDR_LENGTH-1:0] ZERO_ADDR = ADDR_LENGTH'(REG_ZERO);

  always_comb begin
    rd      = mem[int'(ra)*WORD_LENGTH +: WORD_LENGTH];
    rd_busy = busy[ra];
`ifdef REGFILE_BYPASS_EN
    // Ascending scan so the highest-index write port overrides, matching storage priority.
    // A forwarded write retires its producer, so busy drops unless a new reserve lands now.
    for (int i = 0; i < NUM_WRITE; i++) begin
      if (we[i] && wa[i*ADDR_LENGTH +: ADDR_LENGTH] == ra) begin
        rd      = wd[i*WORD_LENGTH +: WORD_LENGTH];
        rd_busy = rsv_en && (rsv_addr == ra);
      end
    end
`endif
    if (reset || ra == ZERO_ADDR) begin
      rd      = '0;
      rd_busy = 1'b0;
    end
  end

`ifndef REGFILE_BYPASS_EN
  logic unused_bypass_inputs;
  assign unused_bypass_inputs = ^{we, wa, wd, rsv_en, rsv_addr};
`endif

endmodule

// File: rtl/scoreboard_register_file.sv
// Integer register file with NUM_READ combinational reads, NUM_WRITE writes and a busy scoreboard.
// Latency: reads zero-cycle; writes/reserves visible after the next rising edge.
// Backpressure: none; every write/reserve is accepted each cycle.
// Ports: clk, reset (sync, active-high); ra/rd/rd_busy per read port (flattened);
// we/wa/wd per write port (flattened, higher index wins); rsv_en/rsv_addr mark a register
// busy; any_busy ORs all busy bits. Optional macro REGFILE_BYPASS_EN enables same-cycle
// write-to-read forwarding inside the read ports.
module scoreboard_register_file
  import rv32_pkg::*;
#(
  parameter int WORD_LENGTH = rv32_pkg::WORD_LENGTH,
  parameter int ADDR_LENGTH = rv32_pkg::ADDR_LENGTH,
  parameter int NUM_READ    = 2,
  parameter int NUM_WRITE   = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_READ*ADDR_LENGTH-1:0]  ra,
  output logic [NUM_READ*WORD_LENGTH-1:0]  rd,
  output logic [NUM_READ-1:0]              rd_busy,
  input  logic [NUM_WRITE-1:0]             we,
  input  logic [NUM_WRITE*ADDR_LENGTH-1:0] wa,
  input  logic [NUM_WRITE*WORD_LENGTH-1:0] wd,
  input  logic                             rsv_en,
  input  logic [ADDR_LENGTH-1:0]           rsv_addr,
  output logic                             any_busy
);

  localparam int DEPTH = 2**ADDR_LENGTH;
  localparam logic [ADDR_LENGTH-1:0] ZERO_ADDR = ADDR_LENGTH'(REG_ZERO);

  logic [DEPTH-1:0][WORD_LENGTH-1:0] mem_q, mem_d;
  logic [DEPTH-1:0]                  busy_q, busy_d;

  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    // Ascending port order: the last matching port's data is what lands.
    for (int i = 0; i < NUM_WRITE; i++) begin
      if (we[i] && wa[i*ADDR_LENGTH +: ADDR_LENGTH] != ZERO_ADDR) begin
        mem_d[wa[i*ADDR_LENGTH +: ADDR_LENGTH]]  = wd[i*WORD_LENGTH +: WORD_LENGTH];
        busy_d[wa[i*ADDR_LENGTH +: ADDR_LENGTH]] = 1'b0;
      end
    end
    // Reserve after writes: a same-cycle reserve is the newer producer and keeps busy set.
    if (rsv_en && rsv_addr != ZERO_ADDR) begin
      busy_d[rsv_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q  <= '0;
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  assign any_busy = ~reset & (|busy_q);

  for (genvar g = 0; g < NUM_READ; g++) begin : g_rp
    regfile_read_port #(
      .WORD_LENGTH (WORD_LENGTH),
      .ADDR_LENGTH (ADDR_LENGTH),
      .NUM_WRITE   (NUM_WRITE)
    ) u_read_port (
      .reset    (reset),
      .ra       (ra[g*ADDR_LENGTH +: ADDR_LENGTH]),
      .mem      (mem_q),
      .busy     (busy_q),
      .we       (we),
      .wa       (wa),
      .wd       (wd),
      .rsv_en   (rsv_en),
      .rsv_addr (rsv_addr),
      .rd       (rd[g*WORD_LENGTH +: WORD_LENGTH]),
      .rd_busy  (rd_busy[g])
    );
  end

endmodule
